axis_merger_n: RTL and testbench

AXIS_MERGER_N -- requirements
Module: axis_merger_n

---
 rtl/axis_merger_n.sv | 130 +++++++++++++
 tb/tb_axis_merger_n.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_merger_n.sv
// N-to-1 AXI-stream merger: drains a fixed beat count from each port in index
// order, then either tails on the last port, wraps around, or stops until cleared.

module axis_merger_n_lane #(
  parameter int CW        = 8,
  parameter bit TAIL_LANE = 1'b0
) (
  input  logic [CW-1:0] count,
  input  logic          sel_hit,
  input  logic          grant,
  output logic          ready,
  output logic          nz
);
  // The tail lane's count is ignored, so it never counts as a bounded port.
  assign nz    = (count != '0) && !TAIL_LANE;
  assign ready = sel_hit && grant;
endmodule

module axis_merger_n #(
  parameter int                           DATA_WIDTH       = 16,
  parameter int                           PORTS            = 3,
  parameter int                           COUNT_WIDTH      = 8,
  parameter logic [PORTS*COUNT_WIDTH-1:0] FROM_PORT_COUNTS = {8'd0, 8'd17, 8'd17},
  parameter int                           MODE             = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [PORTS-1:0]              input_valid,
  output logic [PORTS-1:0]              input_ready,
  input  logic [PORTS*DATA_WIDTH-1:0]   input_data,
  output logic                          output_valid,
  input  logic                          output_ready,
  output logic [DATA_WIDTH-1:0]         output_data,
  output logic [$clog2(PORTS)-1:0]      output_port,
  output logic                          output_last
);
  localparam int SW = $clog2(PORTS);
  localparam logic [1:0] ST_PORT = 2'd0;
  localparam logic [1:0] ST_TAIL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic [PORTS-1:0][COUNT_WIDTH-1:0] counts;
  logic [PORTS-1:0][DATA_WIDTH-1:0]  data_arr;
  logic [PORTS-1:0]                  nz;
  logic [1:0]                        state, start_state;
  logic [SW-1:0]                     sel, start_sel, nxt_sel;
  logic [COUNT_WIDTH-1:0]            cnt;
  logic                              any_nz, nxt_found, active, grant, at_end, xfer;

  assign counts   = FROM_PORT_COUNTS;
  assign data_arr = input_data;

  for (genvar i = 0; i < PORTS; i++) begin : g_lane
    axis_merger_n_lane #(
      .CW       (COUNT_WIDTH),
      .TAIL_LANE(MODE == 0 && i == PORTS-1)
    ) u_lane (
      .count  (counts[i]),
      .sel_hit(sel == SW'(i)),
      .grant  (grant),
      .ready  (input_ready[i]),
      .nz     (nz[i])
    );
  end

  // Lowest bounded port; also the wrap target in cyclic mode.
  always_comb begin
    any_nz      = 1'b0;
    start_sel   = '0;
    start_state = ST_PORT;
    for (int j = PORTS-1; j >= 0; j--)
      if (nz[j]) begin
        any_nz    = 1'b1;
        start_sel = SW'(j);
      end
    if (!any_nz) begin
      if (MODE == 0) begin
        start_state = ST_TAIL;
        start_sel   = SW'(PORTS-1);
      end else begin
        start_state = ST_DONE;
      end
    end
  end

  always_comb begin
    nxt_found = 1'b0;
    nxt_sel   = '0;
    for (int j = PORTS-1; j >= 0; j--)
      if (nz[j] && j > int'(sel)) begin
        nxt_found = 1'b1;
        nxt_sel   = SW'(j);
      end
  end

  assign active       = rst && !clear && (state != ST_DONE);
  assign grant        = active && output_ready;
  assign output_valid = active && input_valid[sel];
  assign output_data  = data_arr[sel];
  assign output_port  = rst ? sel : start_sel;
  assign at_end       = (state == ST_PORT) && (cnt == counts[sel] - CNT_ONE);
  assign output_last  = (MODE != 0) && active && at_end && !nxt_found;
  assign xfer         = output_valid && output_ready;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      state <= start_state;
      sel   <= start_sel;
      cnt   <= '0;
    end else if (xfer && state == ST_PORT) begin
      if (!at_end) begin
        cnt <= cnt + CNT_ONE;
      end else begin
        cnt <= '0;
        if (nxt_found) begin
          sel <= nxt_sel;
        end else if (MODE == 0) begin
          state <= ST_TAIL;
          sel   <= SW'(PORTS-1);
        end else if (MODE == 1) begin
          sel <= start_sel;
        end else begin
          state <= ST_DONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_merger_n.sv
// Scoreboard bench: three merger instances (tail, cyclic, one-shot) fed by
// counting sources; expected beats are queued by the stimulus, popped by a monitor.

module tb_axis_merger_n;
  typedef struct packed {
    logic [1:0]  port;
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        init;
  logic        rst[3], clear[3], ordy[3], ov[3], olast[3];
  logic [2:0]  ivld[3], irdy[3];
  logic [47:0] idata[3];
  logic [15:0] odata[3];
  logic [1:0]  oport[3];
  logic [11:0] seq[3][3];

  exp_t        q[3][$];
  int          exp_seq[3][3];
  int          nassert = 0;
  int          nfail = 0;

  logic        st_pend[3];
  logic [15:0] h_data[3];
  logic [1:0]  h_port[3];
  logic        h_last[3];

  always #5 clk = ~clk;

  axis_merger_n #(.MODE(0)) u0 (
    .clk(clk), .rst(rst[0]), .clear(clear[0]), .input_valid(ivld[0]), .input_ready(irdy[0]),
    .input_data(idata[0]), .output_valid(ov[0]), .output_ready(ordy[0]), .output_data(odata[0]),
    .output_port(oport[0]), .output_last(olast[0]));

  axis_merger_n #(.MODE(1), .FROM_PORT_COUNTS({8'd3, 8'd0, 8'd2})) u1 (
    .clk(clk), .rst(rst[1]), .clear(clear[1]), .input_valid(ivld[1]), .input_ready(irdy[1]),
    .input_data(idata[1]), .output_valid(ov[1]), .output_ready(ordy[1]), .output_data(odata[1]),
    .output_port(oport[1]), .output_last(olast[1]));

  axis_merger_n #(.MODE(2), .FROM_PORT_COUNTS({8'd1, 8'd1, 8'd1})) u2 (
    .clk(clk), .rst(rst[2]), .clear(clear[2]), .input_valid(ivld[2]), .input_ready(irdy[2]),
    .input_data(idata[2]), .output_valid(ov[2]), .output_ready(ordy[2]), .output_data(odata[2]),
    .output_port(oport[2]), .output_last(olast[2]));

  // Sources: each word is {port, running beat index of that port}.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      idata[k] = '0;
      for (int p = 0; p < 3; p++) idata[k][p*16 +: 16] = {4'(p), seq[k][p]};
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 3; p++)
        if (init) seq[k][p] <= '0;
        else if (ivld[k][p] && irdy[k][p]) seq[k][p] <= seq[k][p] + 12'd1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input int p, input logic last);
    exp_t e;
    e.port = 2'(p);
    e.data = {4'(p), 12'(exp_seq[k][p])};
    e.last = last;
    exp_seq[k][p]++;
    q[k].push_back(e);
  endtask

  task automatic run(input int k, input bit stall);
    int guard = 0;
    while (q[k].size() > 0 && guard < 3000) begin
      ivld[k] = stall ? 3'($urandom_range(0, 7)) : 3'b111;
      ordy[k] = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    ordy[k] = 1'b0;
    ivld[k] = 3'b111;
    chk($sformatf("drain_timeout_%0d", k), 64'(q[k].size()), 64'd0);
    q[k].delete();
  endtask

  // Monitor: pops on every handshake, and checks hold-stability under stall.
  initial begin
    exp_t e;
    for (int k = 0; k < 3; k++) st_pend[k] = 1'b0;
    forever begin
      @(negedge clk);
      if (!init) begin
        for (int k = 0; k < 3; k++) begin
          if (st_pend[k] && ov[k])
            chk($sformatf("stall_hold_%0d", k), {odata[k], oport[k], olast[k]},
                {h_data[k], h_port[k], h_last[k]});
          st_pend[k] = ov[k] && !ordy[k];
          h_data[k]  = odata[k];
          h_port[k]  = oport[k];
          h_last[k]  = olast[k];
          if (ov[k] && ordy[k]) begin
            if (k == 1) chk("mode1_port1_ready", irdy[1][1], 1'b0);
            if (q[k].size() == 0) begin
              chk($sformatf("unexpected_beat_%0d", k), {oport[k], odata[k]}, 64'd0);
            end else begin
              e = q[k].pop_front();
              chk($sformatf("beat_%0d", k), {oport[k], odata[k], olast[k]},
                  {e.port, e.data, e.last});
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    init = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; clear[k] = 1'b0; ordy[k] = 1'b1; ivld[k] = 3'b111;
      for (int p = 0; p < 3; p++) exp_seq[k][p] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_valid_%0d", k), ov[k], 1'b0);
      chk($sformatf("reset_ready_%0d", k), irdy[k], 3'b000);
      chk($sformatf("reset_port_%0d", k), oport[k], 2'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin rst[k] = 1'b1; ordy[k] = 1'b0; end
    init = 1'b0;

    // Tail mode: 17 from port 0, 17 from port 1, then port 2 forever.
    for (int i = 0; i < 17; i++) push(0, 0, 1'b0);
    for (int i = 0; i < 17; i++) push(0, 1, 1'b0);
    for (int i = 0; i < 222; i++) push(0, 2, 1'b0);
    run(0, 1'b0);

    clear[0] = 1'b1; ordy[0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("clear_valid", ov[0], 1'b0);
      chk("clear_ready", irdy[0], 3'b000);
      @(posedge clk); #1;
    end
    clear[0] = 1'b0; ordy[0] = 1'b0;

    // Restart under random valid and 1-in-3 ready.
    for (int i = 0; i < 17; i++) push(0, 0, 1'b0);
    for (int i = 0; i < 17; i++) push(0, 1, 1'b0);
    for (int i = 0; i < 10; i++) push(0, 2, 1'b0);
    run(0, 1'b1);

    // Cyclic mode: 0,0,2,2,2 with last on every 5th beat.
    for (int r = 0; r < 2; r++) begin
      push(1, 0, 1'b0); push(1, 0, 1'b0);
      push(1, 2, 1'b0); push(1, 2, 1'b0); push(1, 2, 1'b1);
    end
    push(1, 0, 1'b0);
    run(1, 1'b0);

    rst[1] = 1'b0; ordy[1] = 1'b1;
    @(negedge clk);
    chk("midrst_valid", ov[1], 1'b0);
    chk("midrst_ready", irdy[1], 3'b000);
    chk("midrst_port", oport[1], 2'd0);
    @(posedge clk); #1;
    rst[1] = 1'b1; ordy[1] = 1'b0;
    push(1, 0, 1'b0); push(1, 0, 1'b0);
    push(1, 2, 1'b0); push(1, 2, 1'b0); push(1, 2, 1'b1);
    run(1, 1'b1);

    // One-shot: one beat per port, then done until clear.
    push(2, 0, 1'b0); push(2, 1, 1'b0); push(2, 2, 1'b1);
    run(2, 1'b0);
    ordy[2] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("done_valid", ov[2], 1'b0);
      chk("done_ready", irdy[2], 3'b000);
    end
    @(posedge clk); #1;
    clear[2] = 1'b1;
    @(posedge clk); #1;
    clear[2] = 1'b0; ordy[2] = 1'b0;
    push(2, 0, 1'b0); push(2, 1, 1'b0); push(2, 2, 1'b1);
    run(2, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
